// File: rtl/pci_master_req.sv
// pci_master_req: PCI bus-master requester that runs the REQ/GNT/FRAME handshake for one local burst-write command
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/ready         local command handshake (ready only in IDLE)
//   cmd_addr, cmd_len       burst start address, phase count minus 1
//   dat_in/valid/ready      per-phase write data; dat_ready marks target-ready in DATA
//   pci_req, pci_grnt       request to / grant from the central arbiter
//   pci_frame, pci_ad(_oe)  transaction active, address/data bus and its enable
//   pci_trdy                target ready
//   done, err               one-cycle completion / abandon pulses
//
// Build option: define PCI_MASTER_RETRY_EN to back off and re-request up to
// RETRY_MAX times after a grant timeout; otherwise the first timeout errors out.
module pci_master_req #(
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned GNT_TIMEOUT  = 12,
  parameter int unsigned TRDY_TIMEOUT = 8,
  parameter int unsigned RETRY_MAX    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      dat_in,
  input  logic             dat_valid,
  output logic             dat_ready,
  output logic             pci_req,
  input  logic             pci_grnt,
  output logic             pci_frame,
  output logic [31:0]      pci_ad,
  output logic             pci_ad_oe,
  input  logic             pci_trdy,
  output logic             done,
  output logic             err
);
  localparam int unsigned GW = $clog2(GNT_TIMEOUT + 1);
  localparam int unsigned TW = $clog2(TRDY_TIMEOUT + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GNT_TIMEOUT - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRDY_TIMEOUT - 1);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_BACKOFF, S_ADDR, S_DATA, S_RELEASE, S_ERR
  } state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, ad_q, ad_d;
  logic [LEN_W-1:0] len_q, len_d, phase_q, phase_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic req_q, req_d, frame_q, frame_d, done_q, done_d, err_q, err_d;
`ifdef PCI_MASTER_RETRY_EN
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);
  logic [RW-1:0] rc_q, rc_d;
`endif
  assign cmd_ready = state_q == S_IDLE;
  assign dat_ready = (state_q == S_DATA) & pci_trdy;
  // Data phases put the live write data on the bus; otherwise the last driven value is held.
  assign pci_ad    = (state_q == S_DATA) ? dat_in : ad_q;
  assign pci_req   = req_q;
  assign pci_frame = frame_q;
  assign pci_ad_oe = frame_q;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ad_d    = ad_q;
    phase_d = phase_q;
    gcnt_d  = gcnt_q;
    tcnt_d  = tcnt_q;
`ifdef PCI_MASTER_RETRY_EN
    rc_d    = rc_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        gcnt_d  = '0;
`ifdef PCI_MASTER_RETRY_EN
        rc_d    = '0;
`endif
        state_d = S_REQ;
      end
      S_REQ: if (pci_grnt) begin
        state_d = S_ADDR;
        ad_d    = addr_q;
        phase_d = '0;
        tcnt_d  = '0;
      end else if (gcnt_q == G_LAST) begin
`ifdef PCI_MASTER_RETRY_EN
        state_d = S_BACKOFF;
`else
        state_d = S_ERR;
`endif
      end else gcnt_d = gcnt_q + 1'b1;
`ifdef PCI_MASTER_RETRY_EN
      S_BACKOFF: begin
        rc_d    = (rc_q == '1) ? rc_q : rc_q + 1'b1;
        gcnt_d  = '0;
        state_d = (rc_d > RW'(RETRY_MAX)) ? S_ERR : S_REQ;
      end
`endif
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        ad_d = dat_in;
        // A completion clears the stall count even on the cycle it would have timed out.
        if (dat_valid & pci_trdy) begin
          tcnt_d = '0;
          if (phase_q == len_q) state_d = S_RELEASE;
          else phase_d = phase_q + 1'b1;
        end else if (tcnt_q == T_LAST) state_d = S_ERR;
        else tcnt_d = tcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Bus outputs are registered from the next state so they line up with the state they describe.
    req_d   = state_d == S_REQ;
    frame_d = (state_d == S_ADDR) | (state_d == S_DATA);
    done_d  = state_d == S_RELEASE;
    err_d   = state_d == S_ERR;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      ad_q    <= '0;
      phase_q <= '0;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PCI_MASTER_RETRY_EN
      rc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ad_q    <= ad_d;
      phase_q <= phase_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PCI_MASTER_RETRY_EN
      rc_q    <= rc_d;
`endif
    end
  end
endmodule

// File: tb/tb_pci_master_req.sv
// tb_pci_master_req: directed table-driven and sequence checks for pci_master_req
module tb_pci_master_req;
  localparam logic [31:0] A = 32'h1000_0000;
  localparam logic [31:0] B = 32'h2000_0040;
`ifdef PCI_MASTER_RETRY_EN
  localparam int W = 4;
  localparam bit RETRY = 1'b1;
`else
  localparam int W = 1;
  localparam bit RETRY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_valid, cmd_ready, dat_valid, dat_ready, pci_req, pci_grnt;
  logic pci_frame, pci_ad_oe, pci_trdy, done, err;
  logic [31:0] cmd_addr, dat_in, pci_ad;
  logic [3:0] cmd_len;
  int n_chk = 0;
  int n_fail = 0;
  int dr_cnt = 0;
  always #5 clk = ~clk;
  pci_master_req dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .dat_in(dat_in), .dat_valid(dat_valid),
    .dat_ready(dat_ready), .pci_req(pci_req), .pci_grnt(pci_grnt), .pci_frame(pci_frame),
    .pci_ad(pci_ad), .pci_ad_oe(pci_ad_oe), .pci_trdy(pci_trdy), .done(done), .err(err)
  );
  typedef struct {
    logic        cv;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] din;
    logic        dv, gnt, trdy;
    logic [6:0]  ctl;
    logic [31:0] ad;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic cv, input logic [31:0] addr, input logic [3:0] len,
                              input logic [31:0] din, input logic dv, input logic gnt,
                              input logic trdy, input logic [6:0] ctl, input logic [31:0] ad);
    vec_t v;
    v.cv = cv; v.addr = addr; v.len = len; v.din = din; v.dv = dv;
    v.gnt = gnt; v.trdy = trdy; v.ctl = ctl; v.ad = ad;
    return v;
  endfunction
  function automatic logic [6:0] ctl_now();
    return {cmd_ready, pci_req, pci_frame, pci_ad_oe, dat_ready, done, err};
  endfunction
  task automatic drive(input logic cv, input logic [31:0] addr, input logic [3:0] len,
                       input logic [31:0] din, input logic dv, input logic gnt, input logic trdy);
    cmd_valid = cv; cmd_addr = addr; cmd_len = len; dat_in = din;
    dat_valid = dv; pci_grnt = gnt; pci_trdy = trdy;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [1:0] exp_q[$];
  initial begin
    // ctl = {cmd_ready, req, frame, ad_oe, dat_ready, done, err}
    // single phase, grant one cycle after req, grant dropped during ADDR
    tbl.push_back(mk(1, A, 0, 0, 0, 0, 0, 7'b1000000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0100000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7'b0100000, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'hA5A5_0001, 1, 0, 1, 7'b0011000, A));
    tbl.push_back(mk(0, 0, 0, 32'hA5A5_0001, 1, 0, 1, 7'b0011100, 32'hA5A5_0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000010, 32'hA5A5_0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000000, 32'hA5A5_0001));
    // burst of 4, immediate grant, two target stalls before the third phase
    tbl.push_back(mk(1, B, 3, 0, 0, 0, 0, 7'b1000000, 32'hA5A5_0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7'b0100000, 32'hA5A5_0001));
    tbl.push_back(mk(1, A, 0, 0, 0, 1, 0, 7'b0011000, B));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0000, 1, 0, 1, 7'b0011100, 32'hC0DE_0000));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0001, 1, 0, 1, 7'b0011100, 32'hC0DE_0001));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0002, 1, 0, 0, 7'b0011000, 32'hC0DE_0002));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0002, 1, 0, 0, 7'b0011000, 32'hC0DE_0002));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0002, 1, 0, 1, 7'b0011100, 32'hC0DE_0002));
    tbl.push_back(mk(0, 0, 0, 32'hC0DE_0003, 1, 0, 1, 7'b0011100, 32'hC0DE_0003));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b0000010, 32'hC0DE_0003));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7'b1000000, 32'hC0DE_0003));
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ctl", ctl_now(), 7'b1000000);
    chk("rst_ad", pci_ad, 32'h0);
    rst_n = 1'b1;
    next_cycle();
    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].addr, tbl[i].len, tbl[i].din, tbl[i].dv, tbl[i].gnt, tbl[i].trdy);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), ctl_now(), tbl[i].ctl);
      chk($sformatf("vec%0d_ad", i), pci_ad, tbl[i].ad);
      if (i >= 7 && dat_ready) dr_cnt++;
      next_cycle();
    end
    chk("burst4_dat_ready_count", dr_cnt, 4);
    // grant never arrives
    drive(1, A, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int w = 0; w < W; w++) begin
      for (int k = 0; k < 12; k++) exp_q.push_back(2'b10);
      if (RETRY) exp_q.push_back(2'b00);
    end
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b00);
    foreach (exp_q[k]) begin
      @(negedge clk);
      chk($sformatf("gnt_tmo[%0d]_req_err_frame", k), {pci_req, err, pci_frame}, {exp_q[k], 1'b0});
      next_cycle();
    end
    // master abort: trdy never comes
    drive(1, A, 1, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 1, 0);
    next_cycle();
    drive(0, 0, 0, 32'h5A, 1, 0, 0);
    @(negedge clk);
    chk("abort_addr_frame", pci_frame, 1'b1);
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("abort_data[%0d]_frame_oe_err", k), {pci_frame, pci_ad_oe, err}, 3'b110);
      next_cycle();
    end
    @(negedge clk);
    chk("abort_err_frame_oe_err_req", {pci_frame, pci_ad_oe, err, pci_req}, 4'b0010);
    next_cycle();
    @(negedge clk);
    chk("abort_idle_ready_err", {cmd_ready, err}, 2'b10);
    next_cycle();
    // grant on the final timeout cycle
    drive(1, B, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk($sformatf("late_gnt_req[%0d]", k), pci_req, 1'b1);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("late_gnt_last_req_err", {pci_req, err}, 2'b10);
    next_cycle();
    drive(0, 0, 0, 32'h77, 1, 0, 1);
    @(negedge clk);
    chk("late_gnt_addr_frame_req_err", {pci_frame, pci_req, err}, 3'b100);
    chk("late_gnt_addr_ad", pci_ad, B);
    next_cycle();
    @(negedge clk);
    chk("late_gnt_data_ready_ad", {dat_ready, pci_ad}, {1'b1, 32'h77});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("late_gnt_done_err_frame", {done, err, pci_frame}, 3'b100);
    next_cycle();
    // reset during the second data phase of four
    drive(1, B, 3, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 1, 0);
    next_cycle();
    drive(0, 0, 0, 32'hE0, 1, 0, 1);
    next_cycle();
    next_cycle();
    #1;
    chk("rst_mid_frame_before", pci_frame, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {pci_req, pci_frame, pci_ad_oe, dat_ready, done, err}, 6'b0);
    chk("rst_mid_ad", pci_ad, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("rst_mid_after[%0d]", k), {cmd_ready, done, err, pci_frame, pci_req}, 5'b10000);
    end
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
